imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch controller for the RV32I instruction memory. Holds the program counter, drives the instruction memory's combinational `address` port, captures the returned `instr` with its PC into a 2-entry fetch queue, and hands instructions to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `QDEPTH`, default 2: fetch-queue entries. Only the value 2 is supported.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `redirect_valid`  in  1: redirect request from execute.
- `redirect_pc`  in  32: redirect target.
- `imem_addr`  out  32: byte address to the instruction memory.
- `imem_instr`  in  32: instruction word from memory, combinational from `imem_addr`.
- `out_valid`  out  1: queue head holds a valid instruction.
- `out_instr`  out  32: queue-head instruction.
- `out_pc`  out  32: PC of the queue-head instruction.
- `out_ready`  in  1: decode accepts the head this cycle.
- `fault`  out  1: misaligned-redirect fault. Present only with `IMEM_MISALIGN_TRAP_EN`.

## Operation
- State:
  - `pc` register, 32 bits.
  - Queue with 2 entries of {instr, pc} and a `count` of 0..2.
  - FSM with states RUN and HALT. HALT exists only with the macro.
- Reset:
  - `pc`=`RESET_PC`, `count`=0, FSM=RUN.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0.
  - `imem_addr`=`RESET_PC`.
- Output side:
  - `imem_addr` = `pc` at all times.
  - `out_*` come directly from the queue-head registers.
- pop = `out_valid & out_ready`.
- push = RUN & !`redirect_valid` & (`count`<2 | pop).
- On push:
  - Enqueue {`imem_instr`, `pc`}.
  - `pc` <= `pc`+4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Simultaneous push and pop with `count`=2: the head advances, the new entry fills the tail, and `count` stays at 2.
- Pop with `count`=0 cannot occur, because `out_valid`=0 when the queue is empty.
- Redirect (`redirect_valid`=1) has priority over push and pop:
  - `count` <= 0, i.e. any pop that cycle is discarded.
  - `pc` <= target.
  - No enqueue that cycle.
- Order is strictly in program order. No entry is ever duplicated or dropped except by a redirect flush.

## Timing
- Fetch latency: the instruction at PC X is visible on `out_*` one cycle after `imem_addr`=X is sampled.
- After reset deassert: `out_valid`=1 on the first rising edge with `out_pc`=`RESET_PC`.
- Redirect issued in cycle N:
  - `out_valid`=0 in cycle N+1.
  - `imem_addr`=target in cycle N+1.
  - First target instruction is valid in cycle N+2.
- Backpressure:
  - With `out_ready` held 0, the queue fills in 2 cycles, then `pc` holds.
  - `out_*` stay stable while `out_valid`=1 and `out_ready`=0.
- Steady state with `out_ready`=1: 1 instruction per cycle.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. The queue contents are lost.

## Configuration
- `IMEM_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fault`=1 and moves the FSM to HALT.
  - Flush and `pc` load occur as for a normal redirect.
  - In HALT: no pushes, `out_valid`=0, `fault` is sticky.
  - An aligned redirect returns the FSM to RUN and clears `fault`.
- Not defined:
  - `redirect_pc[1:0]` is forced to 0.
  - No `fault` port, no HALT state.

## Structure
- Package `imem_pkg`:
  - `XLEN`=32.
  - `ILEN`=32.
  - `PC_STEP`=4.
  - Typedef `fetch_entry_t` {instr, pc}.
  - Enum `fetch_state_e` {RUN, HALT}.
- Sub-module `fetch_queue`: a 2-entry FIFO of `fetch_entry_t` with push, pop and flush inputs, and valid and count outputs.
- `imem_fetch_ctrl` contains the PC, the FSM and the push/pop/redirect logic.

## Test plan
- **Reset stream:** memory holds word k = 32'h0000_1000+k; hold `out_ready`=1 after reset → accepted pairs (pc, instr) are (0, 1000), (4, 1001), (8, 1002), one per cycle.
- **Backpressure:** hold `out_ready`=0 for 5 cycles → `count`=2, `imem_addr` holds at 8, and the head stays at (0, 1000). Then release → 0, 4, 8 are delivered in order with no gap or duplicate.
- **Redirect mid-stream:** assert `redirect_valid`, `redirect_pc`=32'h40 while the queue is full and `out_ready`=1 → the next cycle has `out_valid`=0, and the following cycle has `out_pc`=0x40.
- **Wrap-around:** redirect to 32'hFFFF_FFFC → `out_pc` sequence is FFFF_FFFC, then 0000_0000.
- **Misaligned redirect:**
  - With `IMEM_MISALIGN_TRAP_EN`: redirect to 32'h42 → `fault`=1 and `out_valid` stays 0. A later redirect to 32'h80 clears `fault`, and `out_pc`=0x80 appears 2 cycles later.
  - Without the macro: redirect to 32'h42 delivers `out_pc`=0x40.
- **Async reset mid-run:** pulse `rst` between clock edges while `count`=2 → `out_valid` drops to 0 immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the RV32I instruction-fetch path.
// Optional feature macro used by consumers: IMEM_MISALIGN_TRAP_EN.
package imem_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order FIFO of fetched {instr, pc}; head is exposed as registers.
// Flush empties the queue but leaves stale data, which is masked by valid.
module fetch_queue
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t head_q, tail_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= din;
          else                 tail_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Simultaneous push/pop keeps the occupancy; with one entry the new
        // word goes straight to the head.
        2'b11: begin
          if (count_q == 2'd1) head_q <= din;
          else begin
            head_q <= tail_q;
            tail_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = head_q;
  assign count = count_q;
  assign valid = (count_q != 2'd0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// RV32I fetch controller: PC, fetch FSM and push/pop/redirect control.
// IMEM_MISALIGN_TRAP_EN adds the fault port and the HALT state.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_instr,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
`ifdef IMEM_MISALIGN_TRAP_EN
  output logic            fault,
`endif
  input  logic            out_ready
);

  logic [XLEN-1:0] pc_q, target;
  fetch_state_e    state_q, state_d;
  logic            push, pop, q_valid;
  logic [1:0]      count;
  fetch_entry_t    din, head;

`ifdef IMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = (redirect_pc[1:0] != 2'b00);
  assign target   = redirect_pc;
  assign fault    = (state_q == HALT);
`else
  assign target = redirect_pc & ~32'h3;
`endif

  always_comb begin
    state_d = state_q;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (redirect_valid) state_d = misalign ? HALT : RUN;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign pop  = q_valid & out_ready;
  assign push = (state_q == RUN) & ~redirect_valid &
                ((count < 2'(QDEPTH)) | pop);

  // Redirect wins over everything; pc wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc_q <= RESET_PC;
    else if (redirect_valid) pc_q <= target;
    else if (push)           pc_q <= pc_q + PC_STEP;
  end

  assign din.instr = imem_instr;
  assign din.pc    = pc_q;

  fetch_queue u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop & ~redirect_valid),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .valid (q_valid),
    .count (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = q_valid;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
